// File: rtl/fp_wb_pkg.sv
// fp_wb_pkg: shared types and constants for the FP divider writeback queue.
//   fp_wb_entry_t : one queued result (data, destination, size code, flags)
//   ST_*          : bit positions inside the sticky STAT register
package fp_wb_pkg;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   dst;
        logic [2:0]   size;
        logic         nan;
        logic         inf;
        logic         sign;
        logic         zero;
    } fp_wb_entry_t;

    localparam int ST_ZERO = 0;
    localparam int ST_INF  = 1;
    localparam int ST_NAN  = 2;
    localparam int ST_OVF  = 3;
    localparam int ST_SPUR = 4;

endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo: synchronous FIFO of fp_wb_entry_t.
//   CLK, RST        : clock, asynchronous active-low reset
//   push, wr_entry  : write wr_entry at the tail (caller guarantees room)
//   pop             : advance the head (caller guarantees non-empty)
//   rd_entry        : head entry (undefined content when empty)
//   full, empty     : occupancy flags
//   count           : number of valid entries, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable:
// full when the wrap bits differ and the index bits match.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  fp_wb_entry_t  wr_entry,
    output fp_wb_entry_t  rd_entry,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = CW - 1;

    fp_wb_entry_t  mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;

    assign full     = (wr_ptr[CW-1] != rd_ptr[CW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; reads are qualified by empty upstream.
    // A push into a full FIFO together with a pop writes the slot the head
    // is vacating, which is safe because the write lands after the edge.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/fpdiv_wb_queue.sv
// fpdiv_wb_queue: writeback queue behind the 128-bit FP divide/sqrt unit.
//   CLK, RST                 : clock, asynchronous active-low reset
//   ISSUE                    : an op was accepted by the divider this cycle
//   RDY, R, DSTo, SR, flags  : single-cycle result pulse from the divider
//   CANISSUE                 : issue permitted next cycle
//   WREQ/WDATA/WDST/WSIZE/WFLAGS, WACK : register-file write port
//   CNT                      : queue occupancy
//   STAT, STATCLR            : sticky {SPUR, OVF, NaN, Inf, Zero}, clear
// Handshake: WREQ is the valid of the head entry and WACK its ready; an
// entry transfers (pops) exactly on a cycle where WREQ & WACK are both 1 at
// the rising edge. WACK without WREQ has no effect, and WREQ plus the head
// fields stay stable until the transfer happens.
module fpdiv_wb_queue
    import fp_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ISSUE,
    input  logic          RDY,
    input  logic [127:0]  R,
    input  logic [3:0]    DSTo,
    input  logic [2:0]    SR,
    input  logic          Zero,
    input  logic          Sign,
    input  logic          Inf,
    input  logic          NaN,
    output logic          CANISSUE,
    output logic          WREQ,
    output logic [127:0]  WDATA,
    output logic [3:0]    WDST,
    output logic [2:0]    WSIZE,
    output logic [3:0]    WFLAGS,
    input  logic          WACK,
    output logic [CW-1:0] CNT,
    output logic [4:0]    STAT,
    input  logic          STATCLR
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CW = (CW + 1)'(DEPTH);

    fp_wb_entry_t  wr_entry;
    fp_wb_entry_t  rd_entry;
    fp_wb_entry_t  head;
    logic          full;
    logic          empty;
    logic          pop_acc;
    logic          push_acc;
    logic [CW-1:0] infl;
    logic [CW:0]   committed;
    logic [4:0]    stat_q;
    logic [4:0]    stat_set;

    assign wr_entry = '{data: R, dst: DSTo, size: SR,
                        nan: NaN, inf: Inf, sign: Sign, zero: Zero};

    assign pop_acc  = WACK & ~empty;
    // A full queue still takes a result if the head leaves in the same cycle.
    assign push_acc = RDY & (~full | pop_acc);

    fp_wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push_acc),
        .pop      (pop_acc),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .full     (full),
        .empty    (empty),
        .count    (CNT)
    );

    // Every queued or in-flight result owns a slot, so the divider can
    // never return more results than the queue can hold.
    assign committed = {1'b0, CNT} + {1'b0, infl};
    assign CANISSUE  = (committed < DEPTH_CW);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            infl <= '0;
        end else if (ISSUE && !RDY) begin
            if (infl != DEPTH_C) infl <= infl + 1'b1;
        end else if (RDY && !ISSUE) begin
            if (infl != '0) infl <= infl - 1'b1;
        end
    end

    always_comb begin
        stat_set = '0;
        if (push_acc) begin
            stat_set[ST_NAN]  = NaN;
            stat_set[ST_INF]  = Inf;
            stat_set[ST_ZERO] = Zero;
        end
        if (RDY && !push_acc)   stat_set[ST_OVF]  = 1'b1;
        if (ISSUE && !CANISSUE) stat_set[ST_OVF]  = 1'b1;
        if (RDY && infl == '0)  stat_set[ST_SPUR] = 1'b1;
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stat_q <= '0;
        else      stat_q <= (STATCLR ? 5'b0 : stat_q) | stat_set;
    end

    assign STAT   = stat_q;
    assign head   = empty ? '0 : rd_entry;
    assign WREQ   = ~empty;
    assign WDATA  = head.data;
    assign WDST   = head.dst;
    assign WSIZE  = head.size;
    assign WFLAGS = {head.nan, head.inf, head.sign, head.zero};

endmodule

// File: tb/tb_fpdiv_wb_queue.sv
module tb_fpdiv_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          RST;
    logic          ISSUE;
    logic          RDY;
    logic [127:0]  R;
    logic [3:0]    DSTo;
    logic [2:0]    SR;
    logic          Zero, Sign, Inf, NaN;
    logic          CANISSUE;
    logic          WREQ;
    logic [127:0]  WDATA;
    logic [3:0]    WDST;
    logic [2:0]    WSIZE;
    logic [3:0]    WFLAGS;
    logic          WACK;
    logic [CW-1:0] CNT;
    logic [4:0]    STAT;
    logic          STATCLR;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_dst;

    fpdiv_wb_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ISSUE(ISSUE), .RDY(RDY), .R(R), .DSTo(DSTo),
        .SR(SR), .Zero(Zero), .Sign(Sign), .Inf(Inf), .NaN(NaN),
        .CANISSUE(CANISSUE), .WREQ(WREQ), .WDATA(WDATA), .WDST(WDST),
        .WSIZE(WSIZE), .WFLAGS(WFLAGS), .WACK(WACK), .CNT(CNT),
        .STAT(STAT), .STATCLR(STATCLR)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // checking
    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ISSUE = 0; RDY = 0; R = '0; DSTo = '0; SR = '0;
        Zero = 0; Sign = 0; Inf = 0; NaN = 0; WACK = 0; STATCLR = 0;
    endtask

    // flags ordered {NaN, Inf, Sign, Zero}
    task automatic rdy_set(input logic [3:0] dst, input logic [3:0] flags);
        RDY = 1; DSTo = dst; SR = 3'd1;
        {NaN, Inf, Sign, Zero} = flags;
    endtask

    task automatic rdy_pulse(input logic [3:0] dst, input logic [3:0] flags);
        rdy_set(dst, flags);
        tick();
        idle();
    endtask

    initial begin
        RST = 1'b1;
        idle();
        #3 RST = 1'b0;
        tick();
        check("rst_wreq", WREQ, 0);
        check("rst_cnt", CNT, 0);
        check("rst_stat", STAT, 0);
        check("rst_canissue", CANISSUE, 1);
        check("rst_wdata", WDATA, 0);
        tick();
        RST = 1'b1;
        tick();

        // single op: issue at cycle 0, result at cycle 30, ack at cycle 33
        ISSUE = 1; tick(); idle();
        check("single_canissue", CANISSUE, 1);
        repeat (29) tick();
        rdy_set(4'd5, 4'b0000);
        SR = 3'd4;
        R  = {32'h3FFF8000, 96'h0};
        tick(); idle();
        check("single_wreq", WREQ, 1);
        check("single_wdst", WDST, 5);
        check("single_wsize", WSIZE, 4);
        check("single_wdata", WDATA, {32'h3FFF8000, 96'h0});
        check("single_cnt", CNT, 1);
        repeat (2) tick();
        WACK = 1; tick(); idle();
        check("single_pop_wreq", WREQ, 0);
        check("single_pop_cnt", CNT, 0);
        check("single_stat", STAT, 0);

        // fill with WACK=0
        for (int i = 0; i < 4; i++) begin
            ISSUE = 1; tick();
        end
        idle();
        check("fill_issue_block", CANISSUE, 0);
        for (int i = 1; i <= 4; i++) begin
            rdy_pulse(4'(i), 4'b0000);
            exp_q.push_back(4'(i));
        end
        check("fill_cnt", CNT, 4);
        check("fill_canissue", CANISSUE, 0);
        check("fill_head", WDST, exp_q[0]);
        check("fill_stat", STAT, 0);

        // issue while blocked sets OVF pre-emptively
        ISSUE = 1; tick(); idle();
        check("issue_blocked_ovf", STAT, 5'b01000);

        // full + simultaneous RDY/WACK, with clear in the same cycle
        check("full_pop_head", WDST, exp_q[0]);
        void'(exp_q.pop_front());
        exp_q.push_back(4'd6);
        rdy_set(4'd6, 4'b0000); WACK = 1; STATCLR = 1;
        tick(); idle();
        check("full_pushpop_cnt", CNT, 4);
        check("full_pushpop_stat", STAT, 0);
        check("full_pushpop_head", WDST, exp_q[0]);

        // full without WACK: result dropped
        ISSUE = 1; tick(); idle();
        STATCLR = 1; tick(); idle();
        check("statclr", STAT, 0);
        rdy_pulse(4'd7, 4'b0000);
        check("drop_stat", STAT, 5'b01000);
        check("drop_cnt", CNT, 4);

        // drain in FIFO order; one pop reopens the issue permit next cycle
        WACK = 1; tick();
        void'(exp_q.pop_front());
        check("drain_cnt", CNT, 3);
        check("drain_canissue", CANISSUE, 1);
        while (exp_q.size() > 0) begin
            exp_dst = exp_q.pop_front();
            check("drain_order", WDST, exp_dst);
            tick();
        end
        check("drain_wreq", WREQ, 0);
        check("drain_wdst_zero", WDST, 0);
        tick();
        check("wack_empty_ignored", CNT, 0);
        idle();
        STATCLR = 1; tick(); idle();

        // sticky flags
        ISSUE = 1; tick(); tick(); idle();
        rdy_pulse(4'd1, 4'b1000);
        rdy_pulse(4'd2, 4'b0100);
        check("flags_stat", STAT, 5'b00110);
        check("flags_cnt", CNT, 2);
        check("flags_head", WFLAGS, 4'b1000);
        ISSUE = 1; tick(); idle();
        rdy_set(4'd3, 4'b0001); STATCLR = 1; tick(); idle();
        check("flags_clr_set_wins", STAT, 5'b00001);
        check("flags_cnt3", CNT, 3);
        WACK = 1; tick();
        check("flags_head2", WFLAGS, 4'b0100);
        tick();
        check("flags_head3", WFLAGS, 4'b0001);
        tick(); idle();
        check("flags_empty", CNT, 0);

        // spurious RDY with nothing in flight
        rdy_pulse(4'd9, 4'b0000);
        check("spur_stat", STAT, 5'b10001);
        check("spur_cnt", CNT, 1);
        check("spur_wdst", WDST, 9);
        ISSUE = 1; tick(); tick(); idle();
        check("spur_infl_zero", CANISSUE, 1);
        ISSUE = 1; rdy_set(4'd10, 4'b0000); tick(); idle();
        check("issue_rdy_cnt", CNT, 2);
        check("issue_rdy_block", CANISSUE, 0);
        WACK = 1; tick(); idle();
        check("issue_rdy_infl", CANISSUE, 1);
        check("issue_rdy_stat", STAT, 5'b10001);

        // asynchronous reset mid-operation: CNT=3, INFL=1
        rdy_pulse(4'd11, 4'b0000);
        rdy_pulse(4'd12, 4'b0000);
        ISSUE = 1; tick(); idle();
        check("pre_rst_cnt", CNT, 3);
        check("pre_rst_canissue", CANISSUE, 0);
        #2 RST = 1'b0;
        #1;
        check("arst_wreq", WREQ, 0);
        check("arst_cnt", CNT, 0);
        check("arst_stat", STAT, 0);
        check("arst_canissue", CANISSUE, 1);
        check("arst_wdata", WDATA, 0);
        check("arst_wdst", WDST, 0);
        tick();
        RST = 1'b1;
        rdy_pulse(4'd13, 4'b0000);
        check("post_rst_spur", STAT, 5'b10000);
        check("post_rst_cnt", CNT, 1);
        check("post_rst_wreq", WREQ, 1);
        check("post_rst_wdst", WDST, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
